alu_arbiter: RTL

Shares the single rv32i ALU between two requesters (req0: execute stage, req1: address/branch helper) using valid/ready handshakes on both the request and response sides. Grants one request per cycle, drives the ALU operand/opcode inputs and its clock enable, and returns the registered ALU result to the requester that issued it. The ALU's own output register is the response buffer: the arbiter stalls the ALU by holding `alu_clk_en_o` low while a response is unaccepted.

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one rv32i ALU between two requesters.
// Optional round-robin arbitration via `ALU_ARB_RR_EN (default: fixed priority, req0 first).
// Ports:
//   clk_i, reset_i (async, active-high)
//   req0_* / req1_* : valid/ready request side (opcode, cmp opcode, operands)
//   rsp0_* / rsp1_* : valid/ready response side; shared rsp_result_o/rsp_cmp_o
//   alu_*           : operand/opcode/clock-enable to the ALU, registered result back
module alu_arbiter #(
  parameter int C_XLEN    = 32,
  parameter int C_ALUOP_W = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [C_ALUOP_W-1:0] req0_opcode_i,
  input  logic [2:0]           req0_cmp_opcode_i,
  input  logic [C_XLEN-1:0]    req0_left_i,
  input  logic [C_XLEN-1:0]    req0_right_i,

  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [C_ALUOP_W-1:0] req1_opcode_i,
  input  logic [2:0]           req1_cmp_opcode_i,
  input  logic [C_XLEN-1:0]    req1_left_i,
  input  logic [C_XLEN-1:0]    req1_right_i,

  output logic                 rsp0_valid_o,
  input  logic                 rsp0_ready_i,
  output logic                 rsp1_valid_o,
  input  logic                 rsp1_ready_i,
  output logic [C_XLEN-1:0]    rsp_result_o,
  output logic                 rsp_cmp_o,

  output logic                 alu_clk_en_o,
  output logic [C_ALUOP_W-1:0] alu_opcode_o,
  output logic [2:0]           alu_cmp_opcode_o,
  output logic [C_XLEN-1:0]    alu_left_o,
  output logic [C_XLEN-1:0]    alu_right_o,
  output logic [C_XLEN-1:0]    alu_cmp_left_o,
  output logic [C_XLEN-1:0]    alu_cmp_right_o,
  input  logic [C_XLEN-1:0]    alu_result_i,
  input  logic                 alu_cmp_i
);

  logic pend_q, pend_d;
  logic owner_q, owner_d;
  logic last_q, last_d;

  logic rsp_take;
  logic issue_ok;
  logic grant;
  logic fire;

  always_comb begin
    rsp_take = pend_q & (owner_q ? rsp1_ready_i : rsp0_ready_i);
    // A held response occupies the ALU output register, so a new op may
    // only issue when nothing is pending or the pending one leaves now.
    issue_ok = ~pend_q | rsp_take;
`ifdef ALU_ARB_RR_EN
    grant = (req0_valid_i & req1_valid_i) ? ~last_q : ~req0_valid_i;
`else
    grant = ~req0_valid_i;
`endif
    req0_ready_o = ~reset_i & issue_ok & ~grant & req0_valid_i;
    req1_ready_o = ~reset_i & issue_ok &  grant & req1_valid_i;
    fire = req0_ready_o | req1_ready_o;
  end

  always_comb begin
    alu_opcode_o     = req0_opcode_i;
    alu_cmp_opcode_o = req0_cmp_opcode_i;
    alu_left_o       = req0_left_i;
    alu_right_o      = req0_right_i;
    if (grant) begin
      alu_opcode_o     = req1_opcode_i;
      alu_cmp_opcode_o = req1_cmp_opcode_i;
      alu_left_o       = req1_left_i;
      alu_right_o      = req1_right_i;
    end
    alu_cmp_left_o  = alu_left_o;
    alu_cmp_right_o = alu_right_o;
  end

  // The ALU only clocks on an issue, which keeps its result stable
  // while a response is back-pressured.
  assign alu_clk_en_o = fire;

  always_comb begin
    pend_d  = pend_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (fire) begin
      pend_d  = 1'b1;
      owner_d = grant;
      last_d  = grant;
    end else if (rsp_take) begin
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign rsp0_valid_o = pend_q & ~owner_q;
  assign rsp1_valid_o = pend_q &  owner_q;
  assign rsp_result_o = alu_result_i;
  assign rsp_cmp_o    = alu_cmp_i;

endmodule
